pc_sequencer: RTL and testbench

//  Program counter for the single-cycle core; sits directly downstream of the branch-target

---
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter for the single-cycle core: sequential advance, signed relative branches,
// halt, three entry points, start/done handshake, illegal-PC fault and run-cycle counter.
module pc_sequencer #(
    parameter int D          = 12,
    parameter int IMEM_DEPTH = 1024,
    parameter int START0     = 0,
    parameter int START1     = 256,
    parameter int START2     = 512,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    prog_sel,
    input  logic          branch_en,
    input  logic          branch_taken,
    input  logic [D-1:0]  target,
    input  logic          halt,
    input  logic          stall,
    output logic [D-1:0]  prog_ctr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cyc_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic signed [D:0] IMEM_LIM = (D+1)'(IMEM_DEPTH);

    state_t               state_q, state_d;
    logic [D-1:0]         prog_ctr_q, prog_ctr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        cyc_cnt_q, cyc_cnt_d;

    logic signed [D:0]    offset;
    logic signed [D:0]    npc;
    logic                 npc_oor;
    logic [D-1:0]         entry_pc;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // One extra bit keeps the sum of an unsigned PC and a signed offset exact.
    always_comb begin
        offset  = (branch_en && branch_taken) ? {target[D-1], target} : (D+1)'(1);
        npc     = $signed({1'b0, prog_ctr_q}) + offset;
        npc_oor = npc[D] || (npc >= IMEM_LIM);
    end

    always_comb begin
        case (prog_sel)
            2'd0:    entry_pc = D'(START0);
            2'd1:    entry_pc = D'(START1);
            default: entry_pc = D'(START2);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        prog_ctr_d = prog_ctr_q;
        err_d      = err_q;
        cyc_cnt_d  = cyc_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (prog_sel == 2'd3) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        prog_ctr_d = entry_pc;
                        err_d      = 1'b0;
                        cyc_cnt_d  = '0;
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cyc_cnt_d = sat_inc(cyc_cnt_q);
                if (!stall) begin
                    if (halt) begin
                        state_d = ST_DONE;
                    end else if (npc_oor) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        prog_ctr_d = npc[D-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            prog_ctr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cyc_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prog_ctr_q <= prog_ctr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    assign prog_ctr = prog_ctr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cyc_cnt  = cyc_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes the expected outputs for each cycle,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_pc_sequencer;

    localparam int D  = 12;
    localparam int CW = 16;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [1:0]    prog_sel;
    logic          branch_en;
    logic          branch_taken;
    logic [D-1:0]  target;
    logic          halt;
    logic          stall;
    logic [D-1:0]  prog_ctr;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] cyc_cnt;

    pc_sequencer #(
        .D(D), .IMEM_DEPTH(1024), .START0(0), .START1(256), .START2(512), .CW(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .prog_sel(prog_sel),
        .branch_en(branch_en), .branch_taken(branch_taken), .target(target),
        .halt(halt), .stall(stall), .prog_ctr(prog_ctr), .busy(busy),
        .done(done), .err(err), .cyc_cnt(cyc_cnt)
    );

    typedef struct {
        logic [D-1:0]  pc;
        logic          busy;
        logic          done;
        logic          err;
        logic [CW-1:0] cyc;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares the current outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (prog_ctr !== e.pc || busy !== e.busy || done !== e.done ||
                err !== e.err || cyc_cnt !== e.cyc) begin
                bad++;
                $display("FAIL %s: got pc=%0d busy=%0b done=%0b err=%0b cyc=%0d, want pc=%0d busy=%0b done=%0b err=%0b cyc=%0d",
                         e.name, prog_ctr, busy, done, err, cyc_cnt,
                         e.pc, e.busy, e.done, e.err, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int pc, input logic b,
                              input logic d, input logic e, input int cyc);
        exp_t x;
        x.pc   = D'(pc);
        x.busy = b;
        x.done = d;
        x.err  = e;
        x.cyc  = CW'(cyc);
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic st, input logic [1:0] ps, input logic be,
                         input logic bt, input int tgt, input logic h, input logic sl);
        start        = st;
        prog_sel     = ps;
        branch_en    = be;
        branch_taken = bt;
        target       = D'(tgt);
        halt         = h;
        stall        = sl;
    endtask

    // One cycle: advance past an edge, state the expected outputs, set the next inputs.
    task automatic step(input string name, input int pc, input logic b, input logic d,
                        input logic e, input int cyc,
                        input logic st, input logic [1:0] ps, input logic be,
                        input logic bt, input int tgt, input logic h, input logic sl);
        tick();
        expect_out(name, pc, b, d, e, cyc);
        drive(st, ps, be, bt, tgt, h, sl);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        expect_out("reset_state", 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);

        // Sequential run from entry point 1, halting at 258
        step("t2_pc256",    256, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("t2_pc257",    257, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        step("t2_pc258",    258, 1, 0, 0, 2,  0, 0, 0, 0, 0, 1, 0);
        step("t2_halt",     258, 0, 1, 0, 3,  1, 1, 0, 0, 0, 0, 0);

        // Relaunch from DONE, walk to PC=300 and exercise branches
        step("t3_relaunch", 256, 1, 0, 0, 0,  0, 0, 1, 1, 44, 0, 0);
        step("t3_at300",    300, 1, 0, 0, 1,  0, 0, 1, 1, -143, 0, 0);
        step("t3_neg143",   157, 1, 0, 0, 2,  0, 0, 1, 1, 143, 0, 0);
        step("t3_back300",  300, 1, 0, 0, 3,  0, 0, 1, 1, 14, 0, 0);
        step("t3_pos14",    314, 1, 0, 0, 4,  0, 0, 1, 1, -14, 0, 0);
        step("t3_back300b", 300, 1, 0, 0, 5,  0, 0, 1, 0, -143, 0, 0);
        step("t3_nottaken", 301, 1, 0, 0, 6,  0, 0, 1, 1, -261, 0, 0);

        // Stall beats halt for three cycles, then a zero-offset spin
        step("t5_at40",     40, 1, 0, 0, 7,   0, 0, 0, 0, 0, 1, 1);
        step("t5_stall1",   40, 1, 0, 0, 8,   0, 0, 0, 0, 0, 1, 1);
        step("t5_stall2",   40, 1, 0, 0, 9,   0, 0, 0, 0, 0, 1, 1);
        step("t5_stall3",   40, 1, 0, 0, 10,  0, 0, 1, 1, 0, 0, 0);
        step("t5_spin1",    40, 1, 0, 0, 11,  0, 0, 1, 1, 0, 0, 0);
        step("t5_spin2",    40, 1, 0, 0, 12,  0, 0, 1, 1, -30, 0, 0);

        // Out-of-range targets below zero and at IMEM_DEPTH
        step("t4_at10",     10, 1, 0, 0, 13,  0, 0, 1, 1, -17, 0, 0);
        step("t4_negpc",    10, 0, 1, 1, 14,  1, 2, 0, 0, 0, 0, 0);
        step("t4_errclr",   512, 1, 0, 0, 0,  0, 0, 1, 1, 508, 0, 0);
        step("t4_at1020",   1020, 1, 0, 0, 1, 0, 0, 1, 1, 3, 0, 0);
        step("t4_at1023",   1023, 1, 0, 0, 2, 0, 0, 1, 1, -3, 0, 0);
        step("t4_back1020", 1020, 1, 0, 0, 3, 0, 0, 1, 1, 4, 0, 0);
        step("t4_hipc",     1020, 0, 1, 1, 4, 1, 3, 0, 0, 0, 0, 0);

        // Handshake: bad select from DONE, relaunch, start ignored while running
        step("t6_sel3_done", 1020, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        step("t6_sel0",     0, 1, 0, 0, 0,    1, 2, 0, 0, 0, 0, 0);
        step("t6_run_ign1", 1, 1, 0, 0, 1,    1, 2, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run, checked before any further rising edge
        tick();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("t1_async", 0, 0, 0, 0, 0);
        tick();
        expect_out("t1_held", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        drive(1, 3, 0, 0, 0, 0, 0);

        step("t6_sel3_idle", 0, 0, 1, 1, 0,   1, 0, 0, 0, 0, 0, 0);
        step("t6_restart",  0, 1, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0);
        step("t6_halt0",    0, 0, 1, 0, 1,    1, 1, 0, 0, 0, 0, 0);
        step("t6_held_start", 256, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("t6_after",    257, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0);

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
